// File: rtl/nx_node_link.sv
// nx_node_link: registered message buffer on one mesh link between two adjacent nx_node instances.
// Cuts every valid/ready path between nodes, absorbs short stalls and reports occupancy and idle state.
package NXConstants;
  localparam int MESSAGE_WIDTH = 32;
endpackage

module nx_node_link #(
  parameter int DEPTH = 4,
  parameter int MESSAGE_WIDTH = NXConstants::MESSAGE_WIDTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [MESSAGE_WIDTH-1:0] i_inbound_data,
  input  logic                     i_inbound_valid,
  output logic                     o_inbound_ready,
  output logic [MESSAGE_WIDTH-1:0] o_outbound_data,
  output logic                     o_outbound_valid,
  input  logic                     i_outbound_ready,
  output logic                     o_present,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_idle
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [MESSAGE_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW-1:0] w_wr_next, w_rd_next, w_count_next;
  logic [MESSAGE_WIDTH-1:0] w_rd_data;
  logic w_push, w_pop;
  assign w_push = i_inbound_valid && o_inbound_ready;
  assign w_pop = o_outbound_valid && i_outbound_ready;
  assign w_wr_next = r_wr_ptr + PW'(w_push);
  assign w_rd_next = r_rd_ptr + PW'(w_pop);
  assign w_count_next = w_wr_next - w_rd_next;
  // the next head may be the very entry being written on this edge
  assign w_rd_data = (w_push && r_wr_ptr == w_rd_next) ? i_inbound_data : r_mem[w_rd_next[AW-1:0]];
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_inbound_data;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      o_inbound_ready  <= 1'b0;
      o_outbound_valid <= 1'b0;
      o_outbound_data  <= '0;
      o_level          <= '0;
      o_idle           <= 1'b1;
      o_present        <= 1'b0;
    end else begin
      r_wr_ptr         <= w_wr_next;
      r_rd_ptr         <= w_rd_next;
      o_inbound_ready  <= w_count_next < PW'(DEPTH);
      o_outbound_valid <= w_count_next != '0;
      o_outbound_data  <= w_rd_data;
      o_level          <= w_count_next;
      o_idle           <= (w_count_next == '0) && !i_inbound_valid;
      o_present        <= 1'b1;
    end
  end
endmodule

// File: tb/tb_nx_node_link.sv
// tb_nx_node_link: scoreboard bench for nx_node_link; a negedge monitor records accepted
// messages and checks order, hold stability and level range, scenario tasks check the rest.
module tb_nx_node_link;
  localparam int W = NXConstants::MESSAGE_WIDTH;
  logic clk, rst_n;
  logic [W-1:0] in_data, o_outbound_data;
  logic in_valid, o_inbound_ready, o_outbound_valid, out_ready, o_present, o_idle;
  logic [2:0] o_level;
  int checks = 0, failures = 0, n_out = 0;
  logic [W-1:0] q[$];
  logic prev_stall = 0;
  logic [W-1:0] prev_data, exp_d;

  nx_node_link #(.DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_inbound_data(in_data), .i_inbound_valid(in_valid), .o_inbound_ready(o_inbound_ready),
    .o_outbound_data(o_outbound_data), .o_outbound_valid(o_outbound_valid),
    .i_outbound_ready(out_ready), .o_present(o_present), .o_level(o_level), .o_idle(o_idle)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!o_outbound_valid || o_outbound_data !== prev_data) begin
          failures++;
          $display("FAIL hold_stable: valid=%0b data=%h required valid=1 data=%h", o_outbound_valid, o_outbound_data, prev_data);
        end
      end
      prev_stall = o_outbound_valid && !out_ready;
      prev_data = o_outbound_data;
      checks++;
      if (o_level > 3'd4) begin
        failures++;
        $display("FAIL level_range: level=%0d required <=4", o_level);
      end
      if (o_outbound_valid && out_ready) begin
        checks++;
        n_out++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL sb_order: got %h required no message", o_outbound_data);
        end else begin
          exp_d = q.pop_front();
          if (o_outbound_data !== exp_d) begin
            failures++;
            $display("FAIL sb_order: got %h required %h", o_outbound_data, exp_d);
          end
        end
      end
      if (in_valid && o_inbound_ready) q.push_back(in_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [W-1:0] d);
    bit acc = 0;
    int n = 0;
    in_valid = 1;
    in_data = d;
    while (!acc && n < 100) begin
      acc = o_inbound_ready;
      tick();
      n++;
    end
    in_valid = 0;
    if (!acc) begin
      failures++;
      $display("FAIL push_timeout: data %h not accepted, required acceptance within 100 cycles", d);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready = 1;
    in_valid = 0;
    while ((o_outbound_valid || q.size() != 0 || o_level != 0) && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (o_outbound_valid || q.size() != 0 || o_level != 0) begin
      failures++;
      $display("FAIL %s_drain: valid=%0b pending=%0d level=%0d required 0/0/0", name, o_outbound_valid, q.size(), o_level);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 0; in_data = '0; out_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_inbound_ready, o_outbound_valid, o_idle, o_present} !== 4'b0010 || o_level !== 3'd0 || o_outbound_data !== '0) begin
      failures++;
      $display("FAIL reset_values: rdy=%0b vld=%0b idle=%0b pres=%0b lvl=%0d data=%h required 0 0 1 0 0 0",
               o_inbound_ready, o_outbound_valid, o_idle, o_present, o_level, o_outbound_data);
    end
    @(posedge clk);
    #1 rst_n = 1;
    checks++;
    if (o_inbound_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_ready: ready=%0b required 0", o_inbound_ready);
    end
    tick();
    checks++;
    if (o_inbound_ready !== 1'b1 || o_present !== 1'b1 || o_idle !== 1'b1) begin
      failures++;
      $display("FAIL reset_after_edge: ready=%0b present=%0b idle=%0b required 1 1 1", o_inbound_ready, o_present, o_idle);
    end
  endtask

  task automatic test_single();
    out_ready = 1;
    in_valid = 1;
    in_data = W'(32'h1234);
    tick();
    in_valid = 0;
    checks++;
    if (o_outbound_valid !== 1'b1 || o_outbound_data !== W'(32'h1234) || o_level !== 3'd1) begin
      failures++;
      $display("FAIL single_out: valid=%0b data=%h level=%0d required 1 00001234 1", o_outbound_valid, o_outbound_data, o_level);
    end
    tick();
    checks++;
    if (o_outbound_valid !== 1'b0 || o_level !== 3'd0) begin
      failures++;
      $display("FAIL single_pop: valid=%0b level=%0d required 0 0", o_outbound_valid, o_level);
    end
    tick();
    checks++;
    if (o_idle !== 1'b1) begin
      failures++;
      $display("FAIL single_idle: idle=%0b required 1", o_idle);
    end
  endtask

  task automatic test_fill();
    int base = n_out;
    out_ready = 0;
    for (int i = 0; i < 4; i++) push_one(W'(32'hA0 + i));
    checks++;
    if (o_inbound_ready !== 1'b0 || o_level !== 3'd4 || o_outbound_data !== W'(32'hA0)) begin
      failures++;
      $display("FAIL fill_full: ready=%0b level=%0d data=%h required 0 4 000000a0", o_inbound_ready, o_level, o_outbound_data);
    end
    in_valid = 1;
    in_data = W'(32'hE0);
    repeat (3) tick();
    checks++;
    if (o_inbound_ready !== 1'b0 || o_level !== 3'd4 || q.size() != 4) begin
      failures++;
      $display("FAIL fill_holdoff: ready=%0b level=%0d pending=%0d required 0 4 4", o_inbound_ready, o_level, q.size());
    end
    out_ready = 1;
    tick();
    checks++;
    if (o_inbound_ready !== 1'b1 || o_level !== 3'd3) begin
      failures++;
      $display("FAIL fill_reopen: ready=%0b level=%0d required 1 3", o_inbound_ready, o_level);
    end
    tick();
    in_valid = 0;
    checks++;
    if (o_level !== 3'd3) begin
      failures++;
      $display("FAIL fill_e_accept: level=%0d required 3", o_level);
    end
    drain("fill");
    checks++;
    if (n_out - base != 5) begin
      failures++;
      $display("FAIL fill_count: delivered=%0d required 5", n_out - base);
    end
  endtask

  task automatic test_stream();
    int base = n_out;
    out_ready = 1;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1;
      in_data = W'($urandom);
      tick();
      checks++;
      if (o_inbound_ready !== 1'b1 || o_level > 3'd1) begin
        failures++;
        $display("FAIL stream_cycle%0d: ready=%0b level=%0d required 1 <=1", i, o_inbound_ready, o_level);
      end
    end
    in_valid = 0;
    drain("stream");
    checks++;
    if (n_out - base != 64) begin
      failures++;
      $display("FAIL stream_count: delivered=%0d required 64", n_out - base);
    end
  endtask

  task automatic test_random();
    int base = n_out, sent = 0, guard = 0;
    bit acc;
    in_valid = 0;
    while (sent < 1000 && guard < 20000) begin
      if (!in_valid && $urandom_range(1) == 1) begin
        in_valid = 1;
        in_data = W'($urandom);
      end
      acc = in_valid && o_inbound_ready;
      out_ready = $urandom_range(1) == 1;
      tick();
      if (acc) begin
        sent++;
        in_valid = 0;
      end
      guard++;
    end
    drain("random");
    checks++;
    if (sent != 1000 || n_out - base != 1000) begin
      failures++;
      $display("FAIL random_count: sent=%0d delivered=%0d required 1000 1000", sent, n_out - base);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    out_ready = 0;
    for (int i = 0; i < 3; i++) push_one(W'(32'hC0 + i));
    checks++;
    if (o_level !== 3'd3 || o_outbound_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_level3: level=%0d valid=%0b required 3 1", o_level, o_outbound_valid);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (o_outbound_valid !== 1'b0 || o_level !== 3'd0 || o_inbound_ready !== 1'b0 || o_idle !== 1'b1) begin
      failures++;
      $display("FAIL mid_async: valid=%0b level=%0d ready=%0b idle=%0b required 0 0 0 1", o_outbound_valid, o_level, o_inbound_ready, o_idle);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    out_ready = 1;
    base = n_out;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (o_outbound_valid !== 1'b0 || o_level !== 3'd0) begin
        failures++;
        $display("FAIL mid_stale%0d: valid=%0b level=%0d required 0 0", i, o_outbound_valid, o_level);
      end
    end
    push_one(W'(32'hBEEF));
    drain("mid");
    checks++;
    if (n_out - base != 1) begin
      failures++;
      $display("FAIL mid_count: delivered=%0d required 1", n_out - base);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
